issue_checker: RTL and testbench
================================

Name: issue_checker

Overview:
Synthesizable, parametrised runtime checker for the issue stage, built into the design alongside issue and the RS. It snapshots RS readiness each cycle and validates every issue slot against four rules: operands ready, no FU oversubscription, no duplicate selection, no re-issue. Violations raise sticky flags, a saturating counter, a first-error record and an optional halt request.

Parameters:
RS_SZ, 16, RS entries
NUM_SLOTS, 3, issue slots per cycle (matches `N)
NUM_CLASSES, 4, FU classes: 0=ALU 1=MULT 2=BRANCH 3=LDST
FU_PER_CLASS, 4, free-bit lanes per class
CNT_W, 16, error counter width
CYC_W, 32, cycle stamp width
HALT_ON_ERROR, 1, 1=assert halt_req on first error

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset
enable  in  1  1=checks active
rs_valid  in  RS_SZ  RS entry occupied (current cycle)
rs_src1_ready  in  RS_SZ  source1 tag cleared
rs_src2_ready  in  RS_SZ  source2 tag cleared
issue_valid  in  NUM_SLOTS  slot issuing this cycle
issue_rs_idx  in  NUM_SLOTS*clog2(RS_SZ)  RS index per slot
issue_class  in  NUM_SLOTS*clog2(NUM_CLASSES)  FU class per slot
fu_free  in  NUM_CLASSES*FU_PER_CLASS  free-bit per FU lane (backpressure)
clear_errors  in  1  clear all error state
err_flags  out  4  sticky: [0]NOT_READY [1]OVERSUB [2]DUP [3]REISSUE
err_count  out  CNT_W  cycles with ≥1 violation, saturating
first_err_valid  out  1  first-error record valid
first_err_code  out  2  index of first error
first_err_slot  out  clog2(NUM_SLOTS)  slot of first error
first_err_cycle  out  CYC_W  cycle stamp of first error
halt_req  out  1  sticky halt request

Behaviour:
- Reset (reset==0 at posedge): all outputs 0. RS snapshot (valid/ready) 0. prev_issued mask 0. Cycle counter 0.
- Each cycle: snap_* <= rs_* ; prev_issued[i] <= 1 for every RS index i issued by a valid slot this cycle; cycle counter +1, wraps at 2^CYC_W.
- Checks are evaluated combinationally at cycle t against snapshot (RS state at t-1) and current issue inputs. Results are registered and visible at t+1.
- NOT_READY: a valid slot s whose idx has snap_valid==0, or snap_src1_ready==0, or snap_src2_ready==0.
- OVERSUB: for some class c, count of valid slots with class c > popcount(fu_free[c]).
- DUP: two valid slots carry the same rs_idx. Flagged on the higher-numbered slot.
- REISSUE: a valid slot's idx has prev_issued==1 (entry issued at t-1 and issued again at t).
- Out-of-range idx (≥RS_SZ) or class (≥NUM_CLASSES) on a valid slot counts as NOT_READY / OVERSUB respectively.
- enable==0: no checks are recorded. Snapshot, prev_issued and cycle counter still update.
- Any violation at t:
  - err_flags |= detected bits.
  - err_count += 1 (once per cycle), holds at 2^CNT_W-1.
- first-error record: captured only when first_err_valid==0.
  - Code priority NOT_READY>OVERSUB>DUP>REISSUE; lowest slot wins within a code. OVERSUB slot = lowest slot of the offending class.
  - first_err_cycle = cycle stamp of t.
- halt_req: set on the first violation when HALT_ON_ERROR==1. Sticky until reset or clear_errors. Never set when HALT_ON_ERROR==0.
- clear_errors at t: clears flags, count, record and halt_req at t+1. Same-cycle violations are then applied on top of the cleared state, so they are not lost. clear_errors does not affect the snapshot or the cycle counter.
- Reset mid-operation overrides everything. The first cycle after reset sees an all-zero snapshot, so any issue in that cycle is NOT_READY.

Test Plan:
- Ready issue: RS[5] valid, src1/2 ready at t-1; slot0 issues idx5, class0, fu_free[0]=4'b0001 -> no flags, err_count=0.
- Not ready: RS[3] src2_ready=0 at t-1; slot1 issues idx3 at cycle 10 -> err_flags=4'b0001, first_err_code=0, slot=1, cycle=10, halt_req=1 at cycle 11.
- Oversub + dup same cycle: slots0,1 both idx7 class1, fu_free[1]=4'b0001 -> flags=4'b0110, code=1, slot=0, err_count=1.
- Reissue: idx2 issued at t and t+1, RS[2] ready both snapshots -> flags[3]=1 at t+2.
- Saturation/clear: CNT_W=2, 5 erroring cycles -> err_count=3. Pulse clear_errors with no error -> all zero next cycle. Pulse clear during a NOT_READY cycle -> flags=4'b0001, count=1.
- HALT_ON_ERROR=0, enable toggled: error while enable=0 -> nothing recorded. Same error with enable=1 -> flag set, halt_req stays 0.

Source files
------------

// File: rtl/issue_checker.sv
// Runtime checker for the issue stage: validates each issue slot against the RS
// readiness snapshot, FU availability, duplicate selection and back-to-back re-issue.
module issue_checker #(
  parameter int RS_SZ         = 16,
  parameter int NUM_SLOTS     = 3,
  parameter int NUM_CLASSES   = 4,
  parameter int FU_PER_CLASS  = 4,
  parameter int CNT_W         = 16,
  parameter int CYC_W         = 32,
  parameter int HALT_ON_ERROR = 1,
  localparam int IDX_W  = (RS_SZ > 1) ? $clog2(RS_SZ) : 1,
  localparam int CLS_W  = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1,
  localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                enable,
  input  logic [RS_SZ-1:0]                    rs_valid,
  input  logic [RS_SZ-1:0]                    rs_src1_ready,
  input  logic [RS_SZ-1:0]                    rs_src2_ready,
  input  logic [NUM_SLOTS-1:0]                issue_valid,
  input  logic [NUM_SLOTS*IDX_W-1:0]          issue_rs_idx,
  input  logic [NUM_SLOTS*CLS_W-1:0]          issue_class,
  input  logic [NUM_CLASSES*FU_PER_CLASS-1:0] fu_free,
  input  logic                                clear_errors,
  output logic [3:0]                          err_flags,
  output logic [CNT_W-1:0]                    err_count,
  output logic                                first_err_valid,
  output logic [1:0]                          first_err_code,
  output logic [SLOT_W-1:0]                   first_err_slot,
  output logic [CYC_W-1:0]                    first_err_cycle,
  output logic                                halt_req
);

  localparam int POP_MAX = (NUM_SLOTS > FU_PER_CLASS) ? NUM_SLOTS : FU_PER_CLASS;
  localparam int POP_W   = $clog2(POP_MAX + 1);

  logic [RS_SZ-1:0]  r_snap_valid;
  logic [RS_SZ-1:0]  r_snap_src1;
  logic [RS_SZ-1:0]  r_snap_src2;
  logic [RS_SZ-1:0]  r_prev_issued;
  logic [CYC_W-1:0]  r_cycle;
  logic [3:0]        r_flags;
  logic [CNT_W-1:0]  r_count;
  logic              r_first_valid;
  logic [1:0]        r_first_code;
  logic [SLOT_W-1:0] r_first_slot;
  logic [CYC_W-1:0]  r_first_cycle;
  logic              r_halt;

  logic [IDX_W-1:0] w_idx [NUM_SLOTS];
  logic [CLS_W-1:0] w_cls [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] w_idx_ok;
  logic [NUM_SLOTS-1:0] w_cls_ok;
  logic [NUM_SLOTS-1:0] w_not_ready;
  logic [NUM_SLOTS-1:0] w_oversub;
  logic [NUM_SLOTS-1:0] w_dup;
  logic [NUM_SLOTS-1:0] w_reissue;
  logic [NUM_CLASSES-1:0][POP_W-1:0] w_cls_cnt;
  logic [NUM_CLASSES-1:0][POP_W-1:0] w_free_cnt;
  logic [NUM_CLASSES-1:0] w_cls_over;
  logic [RS_SZ-1:0] w_issue_mask;

  logic [3:0]        w_det;
  logic              w_any;
  logic [3:0]        w_flags_base;
  logic [CNT_W-1:0]  w_count_base;
  logic              w_fv_base;
  logic              w_halt_base;
  logic [3:0]        w_flags_next;
  logic [CNT_W-1:0]  w_count_next;
  logic              w_fv_next;
  logic [1:0]        w_code_next;
  logic [SLOT_W-1:0] w_slot_next;
  logic [CYC_W-1:0]  w_cyc_next;
  logic              w_halt_next;

  function automatic logic [SLOT_W-1:0] lowest_slot(input logic [NUM_SLOTS-1:0] v);
    lowest_slot = '0;
    for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
      if (v[s]) lowest_slot = SLOT_W'(s);
    end
  endfunction

  // Out-of-range index/class are folded into NOT_READY/OVERSUB respectively.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      assign w_idx[gi]    = issue_rs_idx[gi*IDX_W +: IDX_W];
      assign w_cls[gi]    = issue_class[gi*CLS_W +: CLS_W];
      assign w_idx_ok[gi] = ({1'b0, w_idx[gi]} < (IDX_W+1)'(RS_SZ));
      assign w_cls_ok[gi] = ({1'b0, w_cls[gi]} < (CLS_W+1)'(NUM_CLASSES));
      assign w_not_ready[gi] = issue_valid[gi] &&
                               (!w_idx_ok[gi] || !r_snap_valid[w_idx[gi]] ||
                                !r_snap_src1[w_idx[gi]] || !r_snap_src2[w_idx[gi]]);
      assign w_reissue[gi] = issue_valid[gi] && w_idx_ok[gi] && r_prev_issued[w_idx[gi]];
      assign w_oversub[gi] = issue_valid[gi] && (!w_cls_ok[gi] || w_cls_over[w_cls[gi]]);
    end
  endgenerate

  always_comb begin
    w_cls_cnt    = '0;
    w_free_cnt   = '0;
    w_cls_over   = '0;
    w_dup        = '0;
    w_issue_mask = '0;
    for (int c = 0; c < NUM_CLASSES; c++) begin
      for (int f = 0; f < FU_PER_CLASS; f++) begin
        w_free_cnt[c] = w_free_cnt[c] + POP_W'(fu_free[c*FU_PER_CLASS + f]);
      end
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (issue_valid[s] && w_cls_ok[s] && (w_cls[s] == CLS_W'(c))) begin
          w_cls_cnt[c] = w_cls_cnt[c] + POP_W'(1);
        end
      end
      w_cls_over[c] = (w_cls_cnt[c] > w_free_cnt[c]);
    end
    // Duplicate is reported against the later slot of each colliding pair.
    for (int s = 1; s < NUM_SLOTS; s++) begin
      for (int j = 0; j < s; j++) begin
        if (issue_valid[s] && issue_valid[j] && (w_idx[s] == w_idx[j])) w_dup[s] = 1'b1;
      end
    end
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (issue_valid[s] && w_idx_ok[s]) w_issue_mask[w_idx[s]] = 1'b1;
    end
  end

  always_comb begin
    w_det        = enable ? {|w_reissue, |w_dup, |w_oversub, |w_not_ready} : 4'b0000;
    w_any        = |w_det;
    w_flags_base = clear_errors ? 4'b0000 : r_flags;
    w_count_base = clear_errors ? '0 : r_count;
    w_fv_base    = clear_errors ? 1'b0 : r_first_valid;
    w_halt_base  = clear_errors ? 1'b0 : r_halt;
    w_code_next  = clear_errors ? 2'd0 : r_first_code;
    w_slot_next  = clear_errors ? '0 : r_first_slot;
    w_cyc_next   = clear_errors ? '0 : r_first_cycle;
    w_flags_next = w_flags_base | w_det;
    w_count_next = (w_any && (w_count_base != {CNT_W{1'b1}})) ? w_count_base + CNT_W'(1)
                                                              : w_count_base;
    w_fv_next    = w_fv_base;
    if (w_any && !w_fv_base) begin
      w_fv_next  = 1'b1;
      w_cyc_next = r_cycle;
      if (w_det[0]) begin
        w_code_next = 2'd0;
        w_slot_next = lowest_slot(w_not_ready);
      end else if (w_det[1]) begin
        w_code_next = 2'd1;
        w_slot_next = lowest_slot(w_oversub);
      end else if (w_det[2]) begin
        w_code_next = 2'd2;
        w_slot_next = lowest_slot(w_dup);
      end else begin
        w_code_next = 2'd3;
        w_slot_next = lowest_slot(w_reissue);
      end
    end
    w_halt_next = w_halt_base | (w_any && (HALT_ON_ERROR != 0));
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_snap_valid  <= '0;
      r_snap_src1   <= '0;
      r_snap_src2   <= '0;
      r_prev_issued <= '0;
      r_cycle       <= '0;
      r_flags       <= '0;
      r_count       <= '0;
      r_first_valid <= 1'b0;
      r_first_code  <= '0;
      r_first_slot  <= '0;
      r_first_cycle <= '0;
      r_halt        <= 1'b0;
    end else begin
      r_snap_valid  <= rs_valid;
      r_snap_src1   <= rs_src1_ready;
      r_snap_src2   <= rs_src2_ready;
      r_prev_issued <= w_issue_mask;
      r_cycle       <= r_cycle + CYC_W'(1);
      r_flags       <= w_flags_next;
      r_count       <= w_count_next;
      r_first_valid <= w_fv_next;
      r_first_code  <= w_code_next;
      r_first_slot  <= w_slot_next;
      r_first_cycle <= w_cyc_next;
      r_halt        <= w_halt_next;
    end
  end

  assign err_flags       = r_flags;
  assign err_count       = r_count;
  assign first_err_valid = r_first_valid;
  assign first_err_code  = r_first_code;
  assign first_err_slot  = r_first_slot;
  assign first_err_cycle = r_first_cycle;
  assign halt_req        = r_halt;

endmodule

// File: tb/tb_issue_checker.sv
// Self-checking bench for issue_checker: two instances (saturating 2-bit counter with
// halt, 16-bit counter without halt) driven from one vector table plus a reset sequence.
module tb_issue_checker;

  typedef struct {
    logic        en;
    logic        clr;
    logic [15:0] rv;
    logic [15:0] r1;
    logic [15:0] r2;
    logic [2:0]  iv;
    logic [3:0]  idx0, idx1, idx2;
    logic [1:0]  c0, c1, c2;
    logic [15:0] fu;
    logic [3:0]  det;
    logic [1:0]  slot;
  } vec_t;

  typedef struct {
    logic [3:0]  flags;
    int unsigned cnt;
    logic        fv;
    logic [1:0]  code;
    logic [1:0]  slot;
    logic [31:0] cyc;
    logic        halt;
  } exp_t;

  typedef struct {
    exp_t a;
    exp_t b;
  } pair_t;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [15:0] rs_valid, rs_src1_ready, rs_src2_ready;
  logic [2:0]  issue_valid;
  logic [11:0] issue_rs_idx;
  logic [5:0]  issue_class;
  logic [15:0] fu_free;
  logic        clear_errors;

  logic [3:0]  a_flags, b_flags;
  logic [1:0]  a_count;
  logic [15:0] b_count;
  logic        a_fv, b_fv;
  logic [1:0]  a_code, b_code;
  logic [1:0]  a_slot, b_slot;
  logic [31:0] a_cyc, b_cyc;
  logic        a_halt, b_halt;

  int checks = 0;
  int errors = 0;
  int unsigned tb_cycle;
  exp_t  m_a, m_b;
  pair_t sb[$];
  vec_t  tbl[27];

  localparam logic [15:0] ALL = 16'hFFFF;

  issue_checker #(.CNT_W(2), .HALT_ON_ERROR(1)) dut_a (
    .clock(clk), .reset(reset), .enable(enable),
    .rs_valid(rs_valid), .rs_src1_ready(rs_src1_ready), .rs_src2_ready(rs_src2_ready),
    .issue_valid(issue_valid), .issue_rs_idx(issue_rs_idx), .issue_class(issue_class),
    .fu_free(fu_free), .clear_errors(clear_errors),
    .err_flags(a_flags), .err_count(a_count), .first_err_valid(a_fv),
    .first_err_code(a_code), .first_err_slot(a_slot), .first_err_cycle(a_cyc),
    .halt_req(a_halt)
  );

  issue_checker #(.CNT_W(16), .HALT_ON_ERROR(0)) dut_b (
    .clock(clk), .reset(reset), .enable(enable),
    .rs_valid(rs_valid), .rs_src1_ready(rs_src1_ready), .rs_src2_ready(rs_src2_ready),
    .issue_valid(issue_valid), .issue_rs_idx(issue_rs_idx), .issue_class(issue_class),
    .fu_free(fu_free), .clear_errors(clear_errors),
    .err_flags(b_flags), .err_count(b_count), .first_err_valid(b_fv),
    .first_err_code(b_code), .first_err_slot(b_slot), .first_err_cycle(b_cyc),
    .halt_req(b_halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog expired");
  end

  function automatic vec_t mk(input logic en, input logic clr, input logic [15:0] rv,
                              input logic [15:0] r2, input logic [2:0] iv,
                              input logic [3:0] i0, input logic [1:0] c0,
                              input logic [3:0] i1, input logic [1:0] c1,
                              input logic [3:0] i2, input logic [1:0] c2,
                              input logic [15:0] fu, input logic [3:0] det,
                              input logic [1:0] slot);
    vec_t v;
    v.en = en; v.clr = clr; v.rv = rv; v.r1 = ALL; v.r2 = r2; v.iv = iv;
    v.idx0 = i0; v.idx1 = i1; v.idx2 = i2; v.c0 = c0; v.c1 = c1; v.c2 = c2;
    v.fu = fu; v.det = det; v.slot = slot;
    return v;
  endfunction

  function automatic exp_t zero_exp();
    exp_t e;
    e.flags = '0; e.cnt = 0; e.fv = 1'b0; e.code = '0; e.slot = '0; e.cyc = '0; e.halt = 1'b0;
    return e;
  endfunction

  function automatic exp_t upd(input exp_t cur, input vec_t v, input int unsigned cmax,
                               input bit halt_en, input logic [31:0] cyc);
    exp_t n = v.clr ? zero_exp() : cur;
    if (v.det != 4'b0000) begin
      n.flags = n.flags | v.det;
      if (n.cnt < cmax) n.cnt = n.cnt + 1;
      if (!n.fv) begin
        n.fv   = 1'b1;
        n.code = v.det[0] ? 2'd0 : v.det[1] ? 2'd1 : v.det[2] ? 2'd2 : 2'd3;
        n.slot = v.slot;
        n.cyc  = cyc;
      end
      if (halt_en) n.halt = 1'b1;
    end
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic compare_all(input pair_t p);
    chk("a_flags", 32'(a_flags), 32'(p.a.flags));
    chk("a_count", 32'(a_count), p.a.cnt);
    chk("a_first_valid", 32'(a_fv), 32'(p.a.fv));
    chk("a_first_code", 32'(a_code), 32'(p.a.code));
    chk("a_first_slot", 32'(a_slot), 32'(p.a.slot));
    chk("a_first_cycle", a_cyc, p.a.cyc);
    chk("a_halt", 32'(a_halt), 32'(p.a.halt));
    chk("b_flags", 32'(b_flags), 32'(p.b.flags));
    chk("b_count", 32'(b_count), p.b.cnt);
    chk("b_first_valid", 32'(b_fv), 32'(p.b.fv));
    chk("b_first_code", 32'(b_code), 32'(p.b.code));
    chk("b_first_slot", 32'(b_slot), 32'(p.b.slot));
    chk("b_first_cycle", b_cyc, p.b.cyc);
    chk("b_halt", 32'(b_halt), 32'(p.b.halt));
  endtask

  // Called at a negedge; drives one cycle of stimulus and checks the registered result.
  task automatic step(input vec_t v);
    pair_t p;
    enable        = v.en;
    clear_errors  = v.clr;
    rs_valid      = v.rv;
    rs_src1_ready = v.r1;
    rs_src2_ready = v.r2;
    issue_valid   = v.iv;
    issue_rs_idx  = {v.idx2, v.idx1, v.idx0};
    issue_class   = {v.c2, v.c1, v.c0};
    fu_free       = v.fu;
    p.a = upd(m_a, v, 3, 1'b1, tb_cycle);
    p.b = upd(m_b, v, 65535, 1'b0, tb_cycle);
    m_a = p.a;
    m_b = p.b;
    sb.push_back(p);
    @(posedge clk);
    tb_cycle++;
    @(negedge clk);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: got empty queue, expected an entry");
    end else begin
      p = sb.pop_front();
      compare_all(p);
      $display("cyc %0d iv=%b det=%b a_flags=%b a_cnt=%0d a_halt=%b b_cnt=%0d b_halt=%b",
               tb_cycle - 1, v.iv, v.det, a_flags, a_count, a_halt, b_count, b_halt);
    end
  endtask

  task automatic check_reset_state();
    pair_t p;
    p.a = zero_exp();
    p.b = zero_exp();
    compare_all(p);
    $display("reset state a_flags=%b a_cnt=%0d b_cnt=%0d", a_flags, a_count, b_count);
  endtask

  initial begin
    tbl[0]  = mk(1, 0, ALL, ALL, 3'b000, 0, 0, 0, 0, 0, 0, ALL, 4'b0000, 0);
    tbl[1]  = mk(1, 0, ALL, ALL, 3'b000, 0, 0, 0, 0, 0, 0, ALL, 4'b0000, 0);
    tbl[2]  = mk(1, 0, ALL, ALL, 3'b001, 5, 0, 0, 0, 0, 0, 16'hFFF1, 4'b0000, 0);
    tbl[3]  = mk(1, 0, ALL, ALL, 3'b000, 0, 0, 0, 0, 0, 0, ALL, 4'b0000, 0);
    tbl[4]  = mk(1, 0, ALL, ALL, 3'b011, 5, 0, 6, 0, 0, 0, 16'hFFF3, 4'b0000, 0);
    tbl[5]  = mk(1, 0, ALL, ALL, 3'b111, 0, 0, 1, 1, 2, 2, ALL, 4'b0000, 0);
    tbl[6]  = mk(1, 0, ALL, ALL, 3'b000, 0, 0, 0, 0, 0, 0, ALL, 4'b0000, 0);
    tbl[7]  = mk(1, 0, ALL, ALL, 3'b111, 8, 3, 9, 3, 10, 3, 16'h7FFF, 4'b0000, 0);
    tbl[8]  = mk(1, 0, ALL, ALL, 3'b000, 0, 0, 0, 0, 0, 0, ALL, 4'b0000, 0);
    tbl[9]  = mk(1, 0, ALL, 16'hFFF7, 3'b000, 0, 0, 0, 0, 0, 0, ALL, 4'b0000, 0);
    tbl[10] = mk(1, 0, ALL, ALL, 3'b010, 0, 0, 3, 0, 0, 0, ALL, 4'b0001, 1);
    tbl[11] = mk(1, 1, ALL, ALL, 3'b000, 0, 0, 0, 0, 0, 0, ALL, 4'b0000, 0);
    tbl[12] = mk(1, 0, ALL, ALL, 3'b011, 7, 1, 7, 1, 0, 0, 16'hFF1F, 4'b0110, 0);
    tbl[13] = mk(1, 1, ALL, ALL, 3'b000, 0, 0, 0, 0, 0, 0, ALL, 4'b0000, 0);
    tbl[14] = mk(1, 0, ALL, ALL, 3'b001, 2, 0, 0, 0, 0, 0, ALL, 4'b0000, 0);
    tbl[15] = mk(1, 0, 16'hFFEF, ALL, 3'b100, 0, 0, 0, 0, 2, 0, ALL, 4'b1000, 2);
    tbl[16] = mk(1, 0, 16'hFFEF, ALL, 3'b001, 4, 0, 0, 0, 0, 0, ALL, 4'b0001, 0);
    tbl[17] = mk(1, 0, 16'hFFEF, ALL, 3'b001, 4, 0, 0, 0, 0, 0, ALL, 4'b1001, 0);
    tbl[18] = mk(1, 0, 16'hFFEF, ALL, 3'b001, 4, 0, 0, 0, 0, 0, ALL, 4'b1001, 0);
    tbl[19] = mk(1, 0, 16'hF7FF, ALL, 3'b001, 4, 0, 0, 0, 0, 0, ALL, 4'b1001, 0);
    tbl[20] = mk(1, 1, ALL, ALL, 3'b001, 11, 0, 0, 0, 0, 0, ALL, 4'b0001, 0);
    tbl[21] = mk(1, 1, 16'hEFFF, ALL, 3'b000, 0, 0, 0, 0, 0, 0, ALL, 4'b0000, 0);
    tbl[22] = mk(0, 0, 16'hEFFF, ALL, 3'b001, 12, 0, 0, 0, 0, 0, ALL, 4'b0000, 0);
    tbl[23] = mk(1, 0, 16'hEFFF, ALL, 3'b000, 0, 0, 0, 0, 0, 0, ALL, 4'b0000, 0);
    tbl[24] = mk(1, 0, 16'hEFFF, ALL, 3'b001, 12, 0, 0, 0, 0, 0, ALL, 4'b0001, 0);
    tbl[25] = mk(1, 1, ALL, ALL, 3'b111, 0, 0, 1, 2, 3, 2, 16'hF1FF, 4'b0010, 1);
    tbl[26] = mk(1, 0, ALL, ALL, 3'b000, 0, 0, 0, 0, 0, 0, ALL, 4'b0000, 0);

    reset = 1'b0; enable = 1'b0; clear_errors = 1'b0;
    rs_valid = '0; rs_src1_ready = '0; rs_src2_ready = '0;
    issue_valid = '0; issue_rs_idx = '0; issue_class = '0; fu_free = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_state();
    reset = 1'b1;
    m_a = zero_exp();
    m_b = zero_exp();
    tb_cycle = 0;

    for (int k = 0; k < 27; k++) step(tbl[k]);

    // Mid-run reset: state wiped, and the first post-reset issue sees an empty snapshot.
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_state();
    reset = 1'b1;
    m_a = zero_exp();
    m_b = zero_exp();
    tb_cycle = 0;
    step(mk(1, 0, ALL, ALL, 3'b001, 5, 0, 0, 0, 0, 0, ALL, 4'b0001, 0));
    step(mk(1, 0, ALL, ALL, 3'b000, 0, 0, 0, 0, 0, 0, ALL, 4'b0000, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
